// File: rtl/piso_8to1.sv
// Parallel-in serial-out converter: accepts N-bit words over valid/ready and
// shifts them out LSB first, with a one-word holding buffer for gapless streaming.
module piso_8to1 #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic [N-1:0] load_data,
  output logic         load_ready,
  input  logic         en,
  output logic         out,
  output logic         out_valid,
  output logic         last,
  output logic         idle
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  sh;
  logic [N-1:0]  hold;
  logic [CW-1:0] cnt;
  logic          hold_full;
  logic          accept;
  logic          xfer;
  logic          at_last;

  assign accept  = load_valid && load_ready;
  assign xfer    = (state == S_SHIFT) && en;
  assign at_last = (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave SHIFT only when the last bit goes out with nothing queued behind it
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (xfer && at_last && !hold_full && !accept) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    load_ready = !hold_full;
    out_valid  = (state == S_SHIFT);
    out        = out_valid && sh[0];
    last       = out_valid && at_last;
    idle       = (state == S_IDLE) && !hold_full;
  end

  // Shifter, bit counter and holding buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        sh  <= load_data;
        cnt <= '0;
      end
    end else begin
      if (xfer && !at_last) begin
        sh  <= {1'b0, sh[N-1:1]};
        cnt <= cnt + CW'(1);
      end else if (xfer) begin
        cnt <= '0;
        if (hold_full) begin
          sh        <= hold;
          hold_full <= 1'b0;
        end else if (accept) begin
          sh <= load_data;
        end else begin
          sh <= '0;
        end
      end
      // A word accepted on the final transfer bypasses the buffer straight into sh
      if (accept && !(xfer && at_last)) begin
        hold      <= load_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_8to1.sv
// Bench for piso_8to1: table-driven single words, hand-written multi-cycle
// sequences, and a bit/byte scoreboard fed on every accepted load.
module tb_piso_8to1;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       en;
  logic       out;
  logic       out_valid;
  logic       last;
  logic       idle;

  int n_vec;
  int n_err;

  logic [1:0] bitq[$];
  logic [7:0] byteq[$];
  logic [7:0] col;
  int         colcnt;
  logic [1:0] exp_bit;
  logic [7:0] exp_byte;

  typedef struct {
    logic [7:0] data;
    int         stall_at;
    int         stall_len;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[8];

  piso_8to1 #(.N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .en         (en),
    .out        (out),
    .out_valid  (out_valid),
    .last       (last),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected bits/bytes pushed on accept, popped on each transfer
  always @(negedge clk) begin
    if (!reset) begin
      bitq.delete();
      byteq.delete();
      col    = '0;
      colcnt = 0;
    end else begin
      if (!out_valid) check("quiet_out", {30'd0, out, last}, 32'd0);
      if (out_valid && en) begin
        if (bitq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_bit: got out=%b last=%b, required no valid bit", out, last);
        end else begin
          exp_bit = bitq.pop_front();
          check("serial_bit", {30'd0, out, last}, {30'd0, exp_bit});
        end
        col = {out, col[7:1]};
        colcnt++;
        if (colcnt == 8) begin
          colcnt = 0;
          if (byteq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL loopback_byte: got %h, required nothing pending", col);
          end else begin
            exp_byte = byteq.pop_front();
            check("loopback_byte", {24'd0, col}, {24'd0, exp_byte});
          end
        end
      end
      if (load_valid && load_ready) begin
        for (int i = 0; i < 8; i++) bitq.push_back({load_data[i], (i == 7) ? 1'b1 : 1'b0});
        byteq.push_back(load_data);
      end
    end
  end

  initial begin
    int  cycles;
    int  bitn;
    int  stalled;
    int  run;
    logic acc;

    n_vec = 0;
    n_err = 0;
    vecs[0] = '{8'hA5, 8, 0, 8};
    vecs[1] = '{8'h81, 2, 3, 11};
    vecs[2] = '{8'h00, 8, 0, 8};
    vecs[3] = '{8'hFF, 8, 0, 8};
    vecs[4] = '{8'h01, 0, 2, 10};
    vecs[5] = '{8'h80, 7, 1, 9};
    vecs[6] = '{8'h5A, 4, 4, 12};
    vecs[7] = '{8'h7E, 8, 0, 8};

    // Reset held under random stimulus
    reset = 1'b0; load_valid = 1'b0; load_data = '0; en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'($urandom); load_data = 8'($urandom); en = 1'($urandom);
      step();
    end
    load_valid = 1'b0; en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", {27'd0, out, out_valid, last, load_ready, idle}, 32'b00011);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("rst_no_bits", {31'd0, out_valid}, 32'd0);
    end
    step();

    // Single words with optional stall, bits checked by scoreboard
    for (int v = 0; v < 8; v++) begin
      load_valid = 1'b1; load_data = vecs[v].data; en = 1'b1;
      @(negedge clk);
      check("vec_ready", {31'd0, load_ready}, 32'd1);
      step();
      load_valid = 1'b0; load_data = ~vecs[v].data;
      cycles = 0; bitn = 0; stalled = 0;
      while (!idle && cycles < 40) begin
        if (bitn == vecs[v].stall_at && stalled < vecs[v].stall_len) begin
          en = 1'b0; stalled++;
        end else begin
          en = 1'b1;
        end
        @(negedge clk);
        if (!en) begin
          check("stall_frozen", {29'd0, out_valid, out, last},
                {29'd0, 1'b1, vecs[v].data[bitn], (bitn == 7) ? 1'b1 : 1'b0});
        end
        if (en && out_valid) bitn++;
        step();
        cycles++;
      end
      check("vec_cycles", 32'(cycles), 32'(vecs[v].exp_cycles));
      check("vec_idle", {31'd0, idle}, 32'd1);
    end

    // Back-to-back 3C, C3 (loaded on cycle 2), FF offered right after
    en = 1'b1; load_valid = 1'b1; load_data = 8'h3C;
    step();
    load_valid = 1'b0; load_data = '0;
    run = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) begin load_valid = 1'b1; load_data = 8'hC3; end
      if (c == 3) begin load_valid = 1'b1; load_data = 8'hFF; end
      @(negedge clk);
      if (c == 2) check("b2b_ready_2nd", {31'd0, load_ready}, 32'd1);
      if (c >= 3 && c <= 8) check("b2b_ready_low", {31'd0, load_ready}, 32'd0);
      if (c == 9) check("b2b_ready_back", {31'd0, load_ready}, 32'd1);
      if (!out_valid) break;
      run++;
      step();
      if (c == 9) load_valid = 1'b0;
    end
    check("b2b_contiguous", 32'(run), 32'd24);
    load_valid = 1'b0;
    step();

    // Reset mid-word with hold full
    en = 1'b1; load_valid = 1'b1; load_data = 8'h55;
    step();
    load_data = 8'h0F;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    check("mid_hold_full", {31'd0, load_ready}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_now", {29'd0, out_valid, load_ready, idle}, 32'b011);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'($urandom); load_data = 8'($urandom);
      step();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("mid_no_residue", {31'd0, out_valid}, 32'd0);
      step();
    end

    // Loopback: random bytes, random en and load gaps
    for (int w = 0; w < 200; w++) begin
      if ($urandom_range(0, 2) == 0) begin
        load_valid = 1'b0; en = ($urandom_range(0, 3) != 0);
        step();
      end
      load_valid = 1'b1; load_data = 8'($urandom); acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
        en = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = load_ready;
        step();
      end
      if (!acc) begin
        n_vec++;
        n_err++;
        $display("FAIL load_timeout: got load_ready=0 for 64 cycles, required acceptance");
      end
      load_valid = 1'b0;
    end
    en = 1'b1;
    cycles = 0;
    while (!idle && cycles < 60) begin
      step();
      cycles++;
    end
    @(negedge clk);
    check("drain_idle", {31'd0, idle}, 32'd1);
    check("drain_bits", 32'(bitq.size()), 32'd0);
    check("drain_bytes", 32'(byteq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_8to1.md
Name: piso_8to1

Overview:
Parallel-in serial-out converter that feeds the AES serial datapath one bit per clock.
- Accepts an N-bit word over a valid/ready load handshake.
- Shifts the word out LSB first (bit 0 first), the order the serial-to-parallel collector on the receive side expects.
- A one-word holding buffer allows back-to-back words with no idle bubble.
- A downstream enable can stall shifting at any bit.

Parameters:
N, 8, word width in bits (N >= 2); counter width is $clog2(N)+1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
load_valid  input  1  upstream offers load_data this cycle
load_data  input  N  word to serialize
load_ready  output  1  block can accept a word this cycle
en  input  1  downstream shift enable; a bit transfers on a cycle with en=1 and out_valid=1
out  output  1  current serial bit
out_valid  output  1  out carries a valid bit
last  output  1  current bit is bit N-1 of its word
idle  output  1  shifter and holding buffer both empty

Behaviour:
- Storage:
  - shift register sh[N-1:0], bit counter cnt, state bit (IDLE/SHIFT);
  - holding register hold[N-1:0] with flag hold_full.
- Reset (asynchronous, reset=0):
  - sh=0, cnt=0, hold=0, hold_full=0, state=IDLE.
  - Outputs: out=0, out_valid=0, last=0, load_ready=1, idle=1.
  - Reset mid-word discards all pending bits and the held word; no further valid bits appear.
- Combinational outputs:
  - load_ready = !hold_full.
  - out_valid = (state==SHIFT).
  - out = out_valid ? sh[0] : 0.
  - last = out_valid && cnt==N-1.
  - idle = (state==IDLE) && !hold_full.
- Accept = load_valid && load_ready, registered on the rising edge.
  - If state==IDLE: the word goes directly into sh, cnt=0, state->SHIFT. The first bit is visible the cycle after the accepting edge (1-cycle latency).
  - If state==SHIFT: the word goes into hold, hold_full=1.
- Transfer (state==SHIFT && en):
  - If not last: sh shifts right by one (MSB filled with 0), cnt++.
  - If last:
    - hold_full=1: sh<=hold, cnt=0, hold_full=0, stay SHIFT. There is no bubble.
    - hold_full=0 and an accept occurs in the same cycle: the accepted word goes directly to sh, cnt=0, stay SHIFT.
    - Neither: state->IDLE, cnt=0, sh=0.
- Stall (state==SHIFT && !en): sh, cnt and out hold their values. Accepts into hold still occur.
- Simultaneous last-transfer with hold_full=1:
  - load_ready was 0 that cycle, so no accept occurs.
  - load_ready returns to 1 on the next cycle.
- Throughput: with en held at 1 and hold kept filled, exactly N valid bits per word, continuous.
- load_data is sampled only on the accepting edge. Later changes have no effect.
- cnt never exceeds N-1 while in SHIFT.

Test Plan:
- Reset: hold reset=0 during random stimulus, then release -> out_valid=0, out=0, last=0, load_ready=1, idle=1; no bits appear until a load.
- Single word 8'hA5, en=1: load at edge k -> out = 1,0,1,0,0,1,0,1 on cycles k+1..k+8; last=1 only on k+8; idle=1 from k+9.
- Back-to-back 8'h3C then 8'hC3, the second loaded during the first's cycle 2, then a third 8'hFF offered immediately:
  - 16 contiguous out_valid cycles carrying 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1;
  - load_ready=0 from the cycle after the second accept until after the first word's last bit;
  - 8'hFF follows with no gap.
- Stall: 8'h81 with en=0 for three cycles after bit 2 -> out and cnt frozen during the stall; the total bit sequence is still 1,0,0,0,0,0,0,1 with last on the 8th transfer.
- Reset mid-operation: reset after 4 bits with hold_full=1 -> out_valid=0 and load_ready=1 immediately, with no residual bits after release.
- Loopback: 200 random bytes with random en and load_valid gaps, fed into the serial collector (its in driven from out, its en driven from out_valid&&en) -> every reassembled byte matches in order.
